mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port synchronous memory (valid/ready/wr_rd/addr/wdata/rdata interface) between NUM_REQ requesters.
- Sits between client blocks and the memory; one memory transaction in flight at a time.
- Latches the winning command, drives a one-cycle valid pulse, waits for ready, then returns an ack and read data to the winner.
- A timeout terminates transactions the memory never answers.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, data width
DEPTH, 32, memory depth
ADDR_WIDTH, $clog2(DEPTH), address width
TIMEOUT, 15, max WAIT cycles before error completion (>=2)

Ports:
clk  in  1  clock
res  in  1  reset, asynchronous, active-low
req  in  NUM_REQ  per-requester request; held with its command until ack
req_wr_rd  in  NUM_REQ  per-requester 1=write 0=read
req_addr  in  NUM_REQ*ADDR_WIDTH  flat packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*WIDTH  flat packed write data
gnt  out  NUM_REQ  one-hot owner of current transaction
ack  out  NUM_REQ  one-cycle completion pulse to owner
err  out  1  valid with ack; 1 = timed out
rsp_rdata  out  WIDTH  read data, valid with ack
mem_valid  out  1  to memory valid
mem_wr_rd  out  1  to memory wr_rd
mem_addr  out  ADDR_WIDTH  to memory addr
mem_wdata  out  WIDTH  to memory wdata
mem_ready  in  1  from memory ready
mem_rdata  in  WIDTH  from memory rdata
busy  out  1  state != IDLE

Behaviour:
- Reset (res=0, async): state=IDLE, rr pointer=0, all outputs 0, timeout counter 0.
- Outputs are registered; no combinational path from req or mem_ready to any output.
- Eligible mask = req & ~ack, so a requester is not re-granted in its own ack cycle.
- Winner: first eligible index searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
- States:
  - IDLE: if any eligible, latch winner's wr_rd/addr/wdata onto mem_*, set gnt=onehot(winner), mem_valid<=1, go ISSUE; else stay.
  - ISSUE: exactly one cycle; mem_valid<=0, clear counter, go WAIT. mem_* command bits hold until the transaction completes.
  - WAIT: counter increments each cycle.
    - If mem_ready=1: rsp_rdata<=mem_rdata (read) or 0 (write); ack[winner]<=1; err<=0.
    - Else if counter reaches TIMEOUT-1: ack[winner]<=1, err<=1, rsp_rdata<=0.
    - On either completion: gnt<=0, ptr<=winner+1 mod NUM_REQ, go IDLE.
    - mem_ready seen in ISSUE is ignored (it is stale).
- ack, err and rsp_rdata are high/valid for exactly one cycle; rsp_rdata returns to 0 afterwards.
- Latency: req sampled at edge 0 -> mem_valid high cycle 1 -> memory ready cycle 2 -> ack high cycle 3. Throughput is one transaction per 3 cycles back-to-back.
- Write and read to the same address from different requesters are ordered by grant order; no forwarding.
- A requester dropping req before ack is illegal; the latched command still completes and ack is still issued.
- Reset mid-transaction: immediate return to IDLE, no ack, pointer=0. Memory-side state is the memory's responsibility.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT), default WIDTH/DEPTH/NUM_REQ constants, onehot/index helper function.
- Sub-module rr_pick: combinational round-robin picker with inputs mask and ptr, outputs onehot, index and any.

Test Plan:
1. Reset held, then released -> gnt/ack/mem_valid/busy all 0, first grant with all req high goes to requester 0.
2. req0 write addr 5 data 0xA5, then req0 read addr 5 -> mem_valid pulse 1 cycle each; read ack 3 cycles after req with rsp_rdata=0xA5, err=0.
3. req[3:0]=1111 held, each dropped on own ack -> grant order 0,1,2,3, acks at cycles 3,6,9,12; re-assert req0 and req2 -> order 0,2.
4. After last grant=1, req1 and req3 asserted together -> 3 granted first, then 1.
5. mem_ready forced 0, req2 read -> ack[2]=1, err=1, rsp_rdata=0 after TIMEOUT=15 WAIT cycles; next request arbitrates normally.
6. res driven low in WAIT -> all outputs 0 same cycle, no ack; after release, req1 alone -> granted, completes with correct data.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the round-robin memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_DEPTH   = 32;
  localparam int unsigned DEF_TIMEOUT = 15;
  localparam int unsigned MAX_REQ     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // One-hot decode of a requester index, sized for the largest supported NUM_REQ.
  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of mask at or after ptr, wrapping.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDXW    = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDXW-1:0]    index,
  output logic               any
);

  int unsigned cand;

  always_comb begin
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    cand   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any && mask[IDXW'(cand)]) begin
        any    = 1'b1;
        index  = IDXW'(cand);
        onehot = NUM_REQ'(idx_to_onehot(3'(cand)));
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between NUM_REQ clients.
// One transaction in flight; unanswered transactions complete with err after TIMEOUT wait cycles.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_wr_rd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          err,
  output logic [WIDTH-1:0]              rsp_rdata,
  output logic                          mem_valid,
  output logic                          mem_wr_rd,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]              mem_wdata,
  input  logic                          mem_ready,
  input  logic [WIDTH-1:0]              mem_rdata,
  output logic                          busy
);

  localparam int unsigned IDXW = $clog2(NUM_REQ);
  localparam int unsigned CNTW = $clog2(TIMEOUT);

  typedef struct packed {
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
  } cmd_t;

  arb_state_e          state_q, state_d;
  logic [IDXW-1:0]     ptr_q, ptr_d;
  logic [IDXW-1:0]     win_q, win_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  cmd_t                cmd_q, cmd_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                err_q, err_d;
  logic [WIDTH-1:0]    rdata_q, rdata_d;
  logic                mvalid_q, mvalid_d;
  logic                busy_q;

  logic [NUM_REQ-1:0]  elig_c;
  logic [NUM_REQ-1:0]  pick_onehot_c;
  logic [IDXW-1:0]     pick_idx_c;
  logic                pick_any_c;
  logic                timeout_c;

  // A requester is never re-granted in its own ack cycle.
  assign elig_c = req & ~ack_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_pick (
    .mask   (elig_c),
    .ptr    (ptr_q),
    .onehot (pick_onehot_c),
    .index  (pick_idx_c),
    .any    (pick_any_c)
  );

  assign timeout_c = (cnt_q == CNTW'(TIMEOUT - 1));

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    err_d    = 1'b0;
    rdata_d  = '0;
    mvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any_c) begin
          state_d     = ISSUE;
          win_d       = pick_idx_c;
          gnt_d       = pick_onehot_c;
          cmd_d.wr_rd = req_wr_rd[pick_idx_c];
          cmd_d.addr  = req_addr[pick_idx_c*ADDR_WIDTH +: ADDR_WIDTH];
          cmd_d.wdata = req_wdata[pick_idx_c*WIDTH +: WIDTH];
          mvalid_d    = 1'b1;
        end
      end

      // mem_ready here belongs to no live request and is ignored.
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end

      WAIT: begin
        cnt_d = cnt_q + CNTW'(1);
        if (mem_ready || timeout_c) begin
          ack_d   = gnt_q;
          err_d   = !mem_ready;
          rdata_d = (mem_ready && !cmd_q.wr_rd) ? mem_rdata : '0;
          gnt_d   = '0;
          ptr_d   = (win_q == IDXW'(NUM_REQ - 1)) ? '0 : win_q + IDXW'(1);
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      cmd_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      mvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      mvalid_q <= mvalid_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign rsp_rdata = rdata_q;
  assign mem_valid = mvalid_q;
  assign mem_wr_rd = cmd_q.wr_rd;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: transaction-level reference model, responding memory, directed scenarios.
module tb_mem_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned TO = 15;

  logic              clk = 1'b0;
  logic              res = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      req_wr_rd = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*W-1:0]    req_wdata = '0;
  logic [N-1:0]      gnt, ack;
  logic              err;
  logic [W-1:0]      rsp_rdata;
  logic              mem_valid, mem_wr_rd;
  logic [AW-1:0]     mem_addr;
  logic [W-1:0]      mem_wdata;
  logic              mem_ready;
  logic [W-1:0]      mem_rdata;
  logic              busy;

  always #5 clk = ~clk;

  mem_rr_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .res(res), .req(req), .req_wr_rd(req_wr_rd), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .err(err), .rsp_rdata(rsp_rdata),
    .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory: answers one cycle after it sees valid, unless ready_en is low.
  bit           ready_en = 1'b1;
  logic [W-1:0] mem_arr [D];
  bit           pend;
  logic         p_wr;
  logic [AW-1:0] p_addr;
  logic [W-1:0] p_wdata;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    pend = 1'b0;
    for (int a = 0; a < int'(D); a++) mem_arr[a] = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ready = 1'b0;
      mem_rdata = '0;
      if (!res) pend = 1'b0;
      else begin
        if (pend && ready_en) begin
          mem_ready = 1'b1;
          if (p_wr) mem_arr[p_addr] = p_wdata;
          else mem_rdata = mem_arr[p_addr];
        end
        pend = 1'b0;
        if (mem_valid) begin
          pend = 1'b1; p_wr = mem_wr_rd; p_addr = mem_addr; p_wdata = mem_wdata;
        end
      end
    end
  end

  // Reference model: one transaction tracked by its age in edges since grant.
  logic [N-1:0]  e_gnt = '0, e_ack = '0, prev_ack, elig;
  logic          e_err = 1'b0, e_mv = 1'b0;
  logic [W-1:0]  e_rdata = '0;
  bit            m_busy = 1'b0;
  int            m_age = 0, m_ptr = 0, m_win = 0;
  logic          m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [W-1:0]  m_wdata = '0;
  logic [W-1:0]  shadow [D];

  initial begin
    for (int a = 0; a < int'(D); a++) shadow[a] = '0;
    forever begin
      @(posedge clk or negedge res);
      if (!res) begin
        m_busy = 1'b0; m_age = 0; m_ptr = 0; m_win = 0;
        e_gnt = '0; e_ack = '0; e_err = 1'b0; e_rdata = '0; e_mv = 1'b0;
      end else begin
        prev_ack = e_ack;
        e_ack = '0; e_err = 1'b0; e_rdata = '0; e_mv = 1'b0;
        if (!m_busy) begin
          elig = req & ~prev_ack;
          for (int k = 0; k < int'(N); k++) begin
            int i;
            i = (m_ptr + k) % int'(N);
            if (!m_busy && elig[i]) begin
              m_busy = 1'b1; m_age = 0; m_win = i;
              e_gnt = '0; e_gnt[i] = 1'b1; e_mv = 1'b1;
              m_wr = req_wr_rd[i];
              m_addr = req_addr[i*AW +: AW];
              m_wdata = req_wdata[i*W +: W];
            end
          end
        end else begin
          m_age++;
          if (m_age >= 2 && (mem_ready || m_age == int'(TO) + 1)) begin
            e_ack[m_win] = 1'b1;
            e_err = !mem_ready;
            if (mem_ready) begin
              if (m_wr) shadow[m_addr] = m_wdata;
              else e_rdata = shadow[m_addr];
            end
            e_gnt = '0;
            m_ptr = (m_win + 1) % int'(N);
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  int checks = 0, failures = 0;
  int cyc = 0;
  int gord = 0;
  logic [N-1:0] last_gnt = '0;
  int ack_cyc [N];
  int ack_dat [N];
  int ack_err [N];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d (0x%0h) expected %0d (0x%0h)", nm, cyc, act, act, exp, exp);
    end
  endtask

  // One cycle: compare against the model at the negedge, log events, drop acked requests.
  task automatic step();
    @(negedge clk);
    cyc++;
    chk("gnt", int'(gnt), int'(e_gnt));
    chk("ack", int'(ack), int'(e_ack));
    chk("err", int'(err), int'(e_err));
    chk("rsp_rdata", int'(rsp_rdata), int'(e_rdata));
    chk("mem_valid", int'(mem_valid), int'(e_mv));
    chk("busy", int'(busy), int'(m_busy));
    if (m_busy) begin
      chk("mem_wr_rd", int'(mem_wr_rd), int'(m_wr));
      chk("mem_addr", int'(mem_addr), int'(m_addr));
      chk("mem_wdata", int'(mem_wdata), int'(m_wdata));
    end
    if (gnt != '0 && gnt != last_gnt)
      for (int i = 0; i < int'(N); i++) if (gnt[i]) gord = gord * 10 + i + 1;
    last_gnt = gnt;
    for (int i = 0; i < int'(N); i++)
      if (ack[i]) begin
        ack_cyc[i] = cyc; ack_dat[i] = int'(rsp_rdata); ack_err[i] = int'(err);
      end
    req = req & ~ack;
  endtask

  task automatic issue(input int i, input bit wr, input int a, input int d);
    req_wr_rd[i] = wr;
    req_addr[i*AW +: AW] = AW'(a);
    req_wdata[i*W +: W] = W'(d);
    req[i] = 1'b1;
    ack_cyc[i] = -1;
  endtask

  task automatic wait_ack(input int i, input int max);
    for (int n = 0; n < max && ack_cyc[i] < 0; n++) step();
    if (ack_cyc[i] < 0) chk("ack_wait_expired", i, -1);
  endtask

  int c0;

  initial begin
    for (int i = 0; i < int'(N); i++) begin ack_cyc[i] = -1; ack_dat[i] = 0; ack_err[i] = 0; end

    // Reset held, then released; first grant with all requesting goes to 0.
    repeat (3) step();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk); #3 res = 1'b1;
    step();
    for (int i = 0; i < int'(N); i++) issue(i, 1'b1, 10 + i, 8'h11 * (i + 1));
    c0 = cyc; gord = 0;
    step();
    chk("first_gnt", int'(gnt), 1);
    chk("first_mem_valid", int'(mem_valid), 1);
    wait_ack(3, 20);
    chk("order_0123", gord, 1234);
    chk("ack0_cyc", ack_cyc[0] - c0, 3);
    chk("ack1_cyc", ack_cyc[1] - c0, 6);
    chk("ack2_cyc", ack_cyc[2] - c0, 9);
    chk("ack3_cyc", ack_cyc[3] - c0, 12);

    // Re-assert 0 and 2 as reads of the data just written.
    issue(0, 1'b0, 12, 0);
    issue(2, 1'b0, 10, 0);
    gord = 0;
    wait_ack(2, 20);
    chk("order_02", gord, 13);
    chk("rd0_data", ack_dat[0], 'h33);
    chk("rd2_data", ack_dat[2], 'h11);

    // Write then read back through requester 0.
    step();
    issue(0, 1'b1, 5, 'hA5);
    wait_ack(0, 20);
    chk("wr_err", ack_err[0], 0);
    chk("wr_rdata_zero", ack_dat[0], 0);
    step();
    issue(0, 1'b0, 5, 0);
    c0 = cyc;
    wait_ack(0, 20);
    chk("rd_latency", ack_cyc[0] - c0, 3);
    chk("rd_data_a5", ack_dat[0], 'hA5);
    chk("rd_err", ack_err[0], 0);
    step();
    chk("rdata_cleared", int'(rsp_rdata), 0);
    chk("ack_cleared", int'(ack), 0);

    // Last grant 1, then 1 and 3 together: 3 first.
    issue(1, 1'b0, 11, 0);
    wait_ack(1, 20);
    chk("rd1_data", ack_dat[1], 'h22);
    step();
    issue(1, 1'b0, 13, 0);
    issue(3, 1'b0, 10, 0);
    c0 = cyc; gord = 0;
    wait_ack(1, 20);
    chk("order_31", gord, 42);
    chk("ack3_first", ack_cyc[3] - c0, 3);
    chk("ack1_second", ack_cyc[1] - c0, 6);
    chk("rd1_data_44", ack_dat[1], 'h44);
    chk("rd3_data_11", ack_dat[3], 'h11);

    // Memory never answers: timeout after TO wait cycles.
    ready_en = 1'b0;
    step();
    issue(2, 1'b0, 12, 0);
    c0 = cyc;
    wait_ack(2, 40);
    chk("to_latency", ack_cyc[2] - c0, 17);
    chk("to_err", ack_err[2], 1);
    chk("to_rdata", ack_dat[2], 0);
    ready_en = 1'b1;
    step();
    issue(0, 1'b0, 5, 0);
    c0 = cyc;
    wait_ack(0, 20);
    chk("post_to_latency", ack_cyc[0] - c0, 3);
    chk("post_to_data", ack_dat[0], 'hA5);

    // Reset while waiting: outputs clear at once, no ack, pointer back to 0.
    ready_en = 1'b0;
    step();
    issue(3, 1'b1, 9, 'h3C);
    step();
    step();
    chk("pre_rst_busy", int'(busy), 1);
    @(posedge clk); #3 res = 1'b0;
    req = '0;
    step();
    chk("mid_rst_gnt", int'(gnt), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_mem_valid", int'(mem_valid), 0);
    chk("mid_rst_ack", int'(ack), 0);
    step();
    @(posedge clk); #3 res = 1'b1;
    ready_en = 1'b1;
    step();
    issue(1, 1'b0, 5, 0);
    c0 = cyc; gord = 0;
    wait_ack(1, 20);
    chk("no_ack_after_rst", ack_cyc[3], -1);
    chk("post_rst_gnt", gord, 2);
    chk("post_rst_latency", ack_cyc[1] - c0, 3);
    chk("post_rst_data", ack_dat[1], 'hA5);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
